div_rem_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder unit in the EX stage.
- Consumes the registered rs1/rs2 operands produced by the register file read in ID, forwarded through ID/EX.
- Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm.
- Raises BUSY so the hazard unit stalls IF/ID/EX, then returns the result together with its destination register to the EX/MEM stage.

---
 rtl/div_rem_if.sv | 33 +++
 rtl/div_rem_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_rem_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_rem_if.sv
// ============================================================================
// div_rem_if : request/response bundle between the EX stage and div_rem_unit
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface div_rem_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [2:0]       FUNCT3;
  logic [WIDTH-1:0] OPERAND_A;
  logic [WIDTH-1:0] OPERAND_B;
  logic [4:0]       RD_ADDR;
  logic             FLUSH;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic [4:0]       RD_OUT;

  modport master (
    output START, FUNCT3, OPERAND_A, OPERAND_B, RD_ADDR, FLUSH,
    input  BUSY, DONE, RESULT, RD_OUT
  );

  modport slave (
    input  START, FUNCT3, OPERAND_A, OPERAND_B, RD_ADDR, FLUSH,
    output BUSY, DONE, RESULT, RD_OUT
  );
endinterface

`default_nettype wire

// File: rtl/div_rem_unit.sv
// ============================================================================
// div_rem_unit : multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_rem_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      CLK,
  input  logic      RESET,
  div_rem_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [WIDTH-1:0] c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero     = {WIDTH{1'b0}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_sel_rem;
  logic [4:0]       r_rd;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_rd_out;

  logic             w_accept;
  logic             w_step;
  logic             w_finish;

  // Operand conditioning for acceptance
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_special;

  assign w_signed   = ~bus.FUNCT3[0];
  assign w_a_neg    = w_signed & bus.OPERAND_A[WIDTH-1];
  assign w_b_neg    = w_signed & bus.OPERAND_B[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (-bus.OPERAND_A) : bus.OPERAND_A;
  assign w_b_mag    = w_b_neg ? (-bus.OPERAND_B) : bus.OPERAND_B;
  assign w_div_zero = (bus.OPERAND_B == c_zero);
  assign w_ovf      = w_signed & (bus.OPERAND_A == c_min_neg) & (bus.OPERAND_B == c_all_ones);
  assign w_special  = w_div_zero | w_ovf;

  // Restoring step: the remainder never reaches the divisor, so the shifted
  // partial remainder fits in WIDTH+1 bits and bit WIDTH of the difference is the borrow.
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;

  assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shifted - {1'b0, r_div};
  assign w_rem_step = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_quo_fix = r_qsign ? (-r_quo) : r_quo;
  assign w_rem_fix = r_rsign ? (-r_rem) : r_rem;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.FLUSH) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.START && bus.FUNCT3[2]) w_state_nxt = w_special ? S_FIX : S_CALC;
        S_CALC:  if (r_cnt == c_cnt_one) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = bus.START & bus.FUNCT3[2] & ~bus.FLUSH;
      S_CALC:  w_step   = ~bus.FLUSH;
      S_FIX:   w_finish = ~bus.FLUSH;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rem     <= c_zero;
      r_quo     <= c_zero;
      r_div     <= c_zero;
      r_cnt     <= '0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_rd      <= 5'd0;
    end else if (w_accept) begin
      r_sel_rem <= bus.FUNCT3[1];
      r_rd      <= bus.RD_ADDR;
      r_cnt     <= c_cnt_init;
      r_div     <= w_b_mag;
      // Special cases preload final values with signs cleared so FIX passes them through
      if (w_div_zero) begin
        r_quo   <= c_all_ones;
        r_rem   <= bus.OPERAND_A;
        r_qsign <= 1'b0;
        r_rsign <= 1'b0;
      end else if (w_ovf) begin
        r_quo   <= c_min_neg;
        r_rem   <= c_zero;
        r_qsign <= 1'b0;
        r_rsign <= 1'b0;
      end else begin
        r_quo   <= w_a_mag;
        r_rem   <= c_zero;
        r_qsign <= w_a_neg ^ w_b_neg;
        r_rsign <= w_a_neg;
      end
    end else if (w_step) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      r_cnt <= r_cnt - c_cnt_one;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= c_zero;
      r_rd_out <= 5'd0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.BUSY   = r_busy;
  assign bus.DONE   = r_done;
  assign bus.RESULT = r_result;
  assign bus.RD_OUT = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_div_rem_unit.sv
// ============================================================================
// tb_div_rem_unit : directed plus random checks of div_rem_unit
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_rem_unit;

  logic CLK;
  logic RESET;

  div_rem_if #(.WIDTH(32)) bus ();

  div_rem_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  // Issue one request and count edges after E0 until DONE is seen.
  // intrude >= 0 pulses a junk START while the unit is busy.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int intrude, output int lat);
    @(negedge CLK);
    bus.START     = 1'b1;
    bus.FUNCT3    = f3;
    bus.OPERAND_A = a;
    bus.OPERAND_B = b;
    bus.RD_ADDR   = rd;
    @(posedge CLK); #1;
    bus.START     = 1'b0;
    bus.OPERAND_A = $urandom;
    bus.OPERAND_B = $urandom;
    bus.RD_ADDR   = 5'($urandom);
    lat = 0;
    while (!bus.DONE && lat < 100) begin
      if (lat == intrude) begin
        bus.START  = 1'b1;
        bus.FUNCT3 = 3'b101;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    bus.START = 1'b0;
  endtask

  task automatic check_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int intrude, input bit pulse_chk);
    int          lat;
    logic [31:0] exp;
    do_op(f3, a, b, rd, intrude, lat);
    exp = ref_result(f3, a, b);
    chk("latency", lat, is_special(f3, a, b) ? 32'd1 : 32'd33);
    chk("result", bus.RESULT, exp);
    chk("rd_out", {27'd0, bus.RD_OUT}, {27'd0, rd});
    chk("busy_at_done", {31'd0, bus.BUSY}, 32'd0);
    last_result = exp;
    last_rd     = rd;
    if (pulse_chk) begin
      @(posedge CLK); #1;
      chk("done_one_cycle", {31'd0, bus.DONE}, 32'd0);
      chk("result_hold", bus.RESULT, exp);
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (bus.DONE) n_done++;
    end
    chk(tag, n_done, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET         = 1'b1;
    bus.START     = 1'b0;
    bus.FUNCT3    = 3'b000;
    bus.OPERAND_A = 32'd0;
    bus.OPERAND_B = 32'd0;
    bus.RD_ADDR   = 5'd0;
    bus.FLUSH     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    chk("rst_result", bus.RESULT, 32'd0);
    chk("rst_rd", {27'd0, bus.RD_OUT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    check_op(3'b101, 32'd100, 32'd7, 5'd3, -1, 1'b1);
    check_op(3'b111, 32'd100, 32'd7, 5'd17, -1, 1'b1);
    check_op(3'b100, -32'sd20, 32'd6, 5'd4, -1, 1'b1);
    check_op(3'b110, -32'sd20, 32'd6, 5'd5, -1, 1'b1);
    check_op(3'b100, 32'd20, -32'sd6, 5'd6, -1, 1'b1);
    check_op(3'b110, 32'd20, -32'sd6, 5'd7, -1, 1'b1);
    check_op(3'b100, 32'h1234_5678, 32'd0, 5'd8, -1, 1'b1);
    check_op(3'b101, 32'h1234_5678, 32'd0, 5'd9, -1, 1'b1);
    check_op(3'b110, 32'h1234_5678, 32'd0, 5'd10, -1, 1'b1);
    check_op(3'b111, 32'h1234_5678, 32'd0, 5'd11, -1, 1'b1);
    check_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, -1, 1'b1);
    check_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, -1, 1'b1);
    check_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, -1, 1'b1);

    // Junk START while busy must not disturb the running operation
    check_op(3'b101, 32'd100, 32'd7, 5'd21, 5, 1'b1);

    // Second request raised during the DONE cycle
    check_op(3'b100, 32'd1000, 32'd9, 5'd22, -1, 1'b0);
    check_op(3'b111, 32'd1000, 32'd9, 5'd23, -1, 1'b1);

    // Invalid FUNCT3 is ignored
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'b001; bus.OPERAND_B = 32'd3;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    chk("invalid_busy", {31'd0, bus.BUSY}, 32'd0);
    watch_no_done("invalid_no_done", 40);

    // FLUSH beats START in the same cycle
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'b101; bus.OPERAND_A = 32'd50; bus.OPERAND_B = 32'd5; bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.FLUSH = 1'b0;
    chk("flush_start_busy", {31'd0, bus.BUSY}, 32'd0);
    watch_no_done("flush_start_no_done", 40);

    // FLUSH at iteration 10
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'b101; bus.OPERAND_A = 32'd1000; bus.OPERAND_B = 32'd3; bus.RD_ADDR = 5'd30;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("flush_done", {31'd0, bus.DONE}, 32'd0);
    chk("flush_result_kept", bus.RESULT, last_result);
    chk("flush_rd_kept", {27'd0, bus.RD_OUT}, {27'd0, last_rd});
    watch_no_done("flush_no_done", 40);

    // FLUSH on the FIX edge
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'b111; bus.OPERAND_A = 32'd77; bus.OPERAND_B = 32'd5; bus.RD_ADDR = 5'd29;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (32) @(posedge CLK);
    @(negedge CLK);
    bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_fix_done", {31'd0, bus.DONE}, 32'd0);
    chk("flush_fix_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("flush_fix_result_kept", bus.RESULT, last_result);
    watch_no_done("flush_fix_no_done", 5);

    // Asynchronous RESET mid-CALC
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'b101; bus.OPERAND_A = 32'd999; bus.OPERAND_B = 32'd4; bus.RD_ADDR = 5'd28;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("arst_done", {31'd0, bus.DONE}, 32'd0);
    chk("arst_result", bus.RESULT, 32'd0);
    chk("arst_rd", {27'd0, bus.RD_OUT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    watch_no_done("arst_no_done", 40);
    last_result = 32'd0;
    last_rd     = 5'd0;

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = {1'b1, 2'($urandom)};
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      check_op(f3, a, b, 5'($urandom), -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
